// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer_if
//  Purpose  : Bundles the command handshake, the datapath control bus and the
//             response channel of the ALU op sequencer.
//  Modports : slave  - the sequencer (consumes cmd_*, alu_result; drives the
//                      register-file / ALU / mux controls and rsp_*)
//             master - the command source and datapath model (opposite sense)
//  Revision : 1.0  initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_li;
    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic [ADDR_W-1:0] cmd_rd;
    logic [3:0]        cmd_shamt;
    logic              cmd_sign;
    logic [DATA_W-1:0] cmd_imm;
    // datapath control
    logic [ADDR_W-1:0] rr1;
    logic [ADDR_W-1:0] rr2;
    logic [ADDR_W-1:0] wr;
    logic              we;
    logic              mux_ctrl;
    logic [DATA_W-1:0] write_data;
    logic [3:0]        op;
    logic [3:0]        shamount;
    logic              sign;
    logic [DATA_W-1:0] alu_result;
    // response channel
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_err;

    modport slave (
        input  cmd_valid, cmd_li, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
               cmd_shamt, cmd_sign, cmd_imm, alu_result,
        output cmd_ready, rr1, rr2, wr, we, mux_ctrl, write_data,
               op, shamount, sign, rsp_valid, rsp_result, rsp_err
    );

    modport master (
        output cmd_valid, cmd_li, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
               cmd_shamt, cmd_sign, cmd_imm, alu_result,
        input  cmd_ready, rr1, rr2, wr, we, mux_ctrl, write_data,
               op, shamount, sign, rsp_valid, rsp_result, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Accepts one ALU or load-immediate command per valid/ready
//             handshake and steps it through register read, execute and
//             writeback, then returns a one-cycle response.
//  Ports    : clk   - rising-edge clock
//             rst_n - synchronous active-low reset
//             bus   - alu_op_sequencer_if.slave (command, datapath, response)
//  Options  : ALU_SEQ_R0_ZERO_EN - when defined, register 0 is read-only:
//             commands targeting rd==0 visit WB without asserting we and
//             respond with result 0.
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 5,   // must match the interface instance
    parameter int DATA_W   = 32   // must match the interface instance
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EX   = 3'd2,
        S_WB   = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    // one extra bit so NUM_REGS == 2**ADDR_W is representable
    localparam logic [ADDR_W:0] c_num_regs = (ADDR_W+1)'(NUM_REGS);

    state_t            state_q,      state_d;
    logic              cmd_ready_q,  cmd_ready_d;
    logic [ADDR_W-1:0] rr1_q,        rr1_d;
    logic [ADDR_W-1:0] rr2_q,        rr2_d;
    logic [ADDR_W-1:0] wr_q,         wr_d;
    logic              we_q,         we_d;
    logic              mux_ctrl_q,   mux_ctrl_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [3:0]        op_q,         op_d;
    logic [3:0]        shamount_q,   shamount_d;
    logic              sign_q,       sign_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_err_q,    rsp_err_d;
    // command fields latched at acceptance
    logic              cmd_li_q,     cmd_li_d;
    logic [ADDR_W-1:0] cmd_rd_q,     cmd_rd_d;
    logic [3:0]        cmd_op_q,     cmd_op_d;
    logic [3:0]        cmd_shamt_q,  cmd_shamt_d;
    logic              cmd_sign_q,   cmd_sign_d;
    logic [DATA_W-1:0] cmd_imm_q,    cmd_imm_d;
    logic [DATA_W-1:0] res_q,        res_d;

    logic w_accept;
    logic w_legal;
    logic w_r0_new;   // incoming command targets a protected r0
    logic w_r0_lat;   // latched command targets a protected r0

    // cmd_ready is only ever high in IDLE, so it alone qualifies acceptance
    assign w_accept = bus.cmd_valid & cmd_ready_q;

    // load-immediate never reads the register file, so only rd matters
    assign w_legal = ({1'b0, bus.cmd_rd} < c_num_regs) &&
                     (bus.cmd_li || (({1'b0, bus.cmd_rs1} < c_num_regs) &&
                                     ({1'b0, bus.cmd_rs2} < c_num_regs)));

`ifdef ALU_SEQ_R0_ZERO_EN
    assign w_r0_new = (bus.cmd_rd == '0);
    assign w_r0_lat = (cmd_rd_q == '0);
`else
    assign w_r0_new = 1'b0;
    assign w_r0_lat = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = 1'b0;
        rr1_d        = rr1_q;
        rr2_d        = rr2_q;
        wr_d         = wr_q;
        we_d         = 1'b0;
        mux_ctrl_d   = 1'b0;
        write_data_d = write_data_q;
        op_d         = op_q;
        shamount_d   = shamount_q;
        sign_d       = sign_q;
        rsp_valid_d  = 1'b0;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        cmd_li_d     = cmd_li_q;
        cmd_rd_d     = cmd_rd_q;
        cmd_op_d     = cmd_op_q;
        cmd_shamt_d  = cmd_shamt_q;
        cmd_sign_d   = cmd_sign_q;
        cmd_imm_d    = cmd_imm_q;
        res_d        = res_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (w_accept) begin
                    cmd_ready_d = 1'b0;
                    cmd_li_d    = bus.cmd_li;
                    cmd_rd_d    = bus.cmd_rd;
                    cmd_op_d    = bus.cmd_op;
                    cmd_shamt_d = bus.cmd_shamt;
                    cmd_sign_d  = bus.cmd_sign;
                    cmd_imm_d   = bus.cmd_imm;
                    if (!w_legal) begin
                        // straight to the error response, datapath untouched
                        state_d      = S_RSP;
                        rsp_valid_d  = 1'b1;
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                    end else if (bus.cmd_li) begin
                        state_d      = S_WB;
                        we_d         = ~w_r0_new;
                        wr_d         = bus.cmd_rd;
                        write_data_d = bus.cmd_imm;
                    end else begin
                        state_d = S_RD;
                        rr1_d   = bus.cmd_rs1;
                        rr2_d   = bus.cmd_rs2;
                    end
                end
            end
            S_RD: begin
                state_d    = S_EX;
                op_d       = cmd_op_q;
                shamount_d = cmd_shamt_q;
                sign_d     = cmd_sign_q;
            end
            S_EX: begin
                // rr1/rr2/op stay put through WB so alu_result is stable
                // when the register file writes it back
                state_d    = S_WB;
                res_d      = bus.alu_result;
                we_d       = ~w_r0_lat;
                wr_d       = cmd_rd_q;
                mux_ctrl_d = 1'b1;
            end
            S_WB: begin
                state_d      = S_RSP;
                rsp_valid_d  = 1'b1;
                rsp_err_d    = 1'b0;
                rsp_result_d = w_r0_lat ? '0 : (cmd_li_q ? cmd_imm_q : res_q);
            end
            S_RSP: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b0;
            rr1_q        <= '0;
            rr2_q        <= '0;
            wr_q         <= '0;
            we_q         <= 1'b0;
            mux_ctrl_q   <= 1'b0;
            write_data_q <= '0;
            op_q         <= '0;
            shamount_q   <= '0;
            sign_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            cmd_li_q     <= 1'b0;
            cmd_rd_q     <= '0;
            cmd_op_q     <= '0;
            cmd_shamt_q  <= '0;
            cmd_sign_q   <= 1'b0;
            cmd_imm_q    <= '0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rr1_q        <= rr1_d;
            rr2_q        <= rr2_d;
            wr_q         <= wr_d;
            we_q         <= we_d;
            mux_ctrl_q   <= mux_ctrl_d;
            write_data_q <= write_data_d;
            op_q         <= op_d;
            shamount_q   <= shamount_d;
            sign_q       <= sign_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            cmd_li_q     <= cmd_li_d;
            cmd_rd_q     <= cmd_rd_d;
            cmd_op_q     <= cmd_op_d;
            cmd_shamt_q  <= cmd_shamt_d;
            cmd_sign_q   <= cmd_sign_d;
            cmd_imm_q    <= cmd_imm_d;
            res_q        <= res_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rr1        = rr1_q;
    assign bus.rr2        = rr2_q;
    assign bus.wr         = wr_q;
    assign bus.we         = we_q;
    assign bus.mux_ctrl   = mux_ctrl_q;
    assign bus.write_data = write_data_q;
    assign bus.op         = op_q;
    assign bus.shamount   = shamount_q;
    assign bus.sign       = sign_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Purpose  : Self-checking bench for alu_op_sequencer. Provides a register
//             file and ALU around the sequencer and compares responses,
//             write pulses and timing with a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    alu_op_sequencer #(.NUM_REGS(8), .ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- datapath environment ----------------
    logic [31:0] rf   [0:31];   // register file driven by the sequencer
    logic [31:0] mreg [0:7];    // reference model register contents

    function automatic logic [31:0] alu_f(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] s,
                                          input logic sg);
        case (o)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << s;
            4'd6: return $unsigned($signed(a) >>> s);
            4'd7: return sg ? {31'd0, $signed(a) < $signed(b)} : {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.op, rf[bus.rr1], rf[bus.rr2], bus.shamount, bus.sign);

    always @(posedge clk) begin
        if (bus.we) rf[bus.wr] <= bus.mux_ctrl ? bus.alu_result : bus.write_data;
    end

    // ---------------- reference model ----------------
    bit          e_we, e_err;
    int          e_lat;
    logic [31:0] e_res;

    task automatic model_cmd(input bit li, input logic [3:0] o, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [3:0] sh, input bit sg, input logic [31:0] imm);
        bit legal, r0;
        logic [31:0] v;
        legal = (rd < 8) && (li || (rs1 < 8 && rs2 < 8));
        r0 = 1'b0;
`ifdef ALU_SEQ_R0_ZERO_EN
        r0 = (rd == 5'd0);
`endif
        if (!legal) begin
            e_lat = 1; e_err = 1'b1; e_res = 32'd0; e_we = 1'b0;
        end else begin
            e_lat = li ? 2 : 4;
            e_err = 1'b0;
            e_we  = !r0;
            v = li ? imm : alu_f(o, mreg[rs1[2:0]], mreg[rs2[2:0]], sh, sg);
            e_res = r0 ? 32'd0 : v;
            if (!r0) mreg[rd[2:0]] = v;
        end
    endtask

    // ---------------- command driver / observer ----------------
    bit          ob_acc_to, ob_mux, ob_after;
    int          ob_lat, ob_we_cnt, ob_ready_busy;
    logic [4:0]  ob_wr, ob_rr1, ob_rr2;
    logic [31:0] ob_res;
    logic        ob_err;

    task automatic scramble();
        bus.cmd_li    = 1'($urandom);
        bus.cmd_op    = 4'($urandom);
        bus.cmd_rs1   = 5'($urandom);
        bus.cmd_rs2   = 5'($urandom);
        bus.cmd_rd    = 5'($urandom);
        bus.cmd_shamt = 4'($urandom);
        bus.cmd_sign  = 1'($urandom);
        bus.cmd_imm   = $urandom;
    endtask

    task automatic send_cmd(input bit li, input logic [3:0] o, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [3:0] sh, input bit sg, input logic [31:0] imm);
        int w;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_li = li; bus.cmd_op = o; bus.cmd_rs1 = rs1;
        bus.cmd_rs2 = rs2; bus.cmd_rd = rd; bus.cmd_shamt = sh; bus.cmd_sign = sg;
        bus.cmd_imm = imm;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        ob_acc_to = (bus.cmd_ready !== 1'b1);
        @(posedge clk); #1;
        // later field changes must be ignored by the sequencer
        bus.cmd_valid = 1'b0;
        scramble();
        ob_lat = 0; ob_we_cnt = 0; ob_ready_busy = 0; ob_mux = 1'b0; ob_wr = '0;
        ob_rr1 = bus.rr1; ob_rr2 = bus.rr2; ob_res = '0; ob_err = 1'b0;
        for (int c = 1; c <= 10 && ob_lat == 0; c++) begin
            if (bus.cmd_ready) ob_ready_busy++;
            if (bus.we) begin
                ob_we_cnt++; ob_wr = bus.wr; ob_mux = bus.mux_ctrl;
            end
            if (bus.rsp_valid) begin
                ob_lat = c; ob_res = bus.rsp_result; ob_err = bus.rsp_err;
            end
            @(posedge clk); #1;
        end
        ob_after = bus.rsp_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (bus.cmd_ready !== 1'b0 || bus.we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.mux_ctrl !== 1'b0)
            $display("FAIL reset_ctrl: got ready/we/rsp/mux=%b%b%b%b expected 0000",
                     bus.cmd_ready, bus.we, bus.rsp_valid, bus.mux_ctrl);
        else n_pass++;
        n_total++;
        if ({bus.rr1, bus.rr2, bus.wr, bus.op, bus.shamount} !== 23'd0 || bus.write_data !== 32'd0 || bus.rsp_result !== 32'd0)
            $display("FAIL reset_data: got rr1=%h rr2=%h wr=%h op=%h wd=%h res=%h expected all 0",
                     bus.rr1, bus.rr2, bus.wr, bus.op, bus.write_data, bus.rsp_result);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", bus.cmd_ready);
        else n_pass++;
    endtask

    task automatic test_load_imm();
        send_cmd(1'b1, 4'd0, 5'd0, 5'd0, 5'd1, 4'd0, 1'b0, 32'hFFFF_FFCB);
        model_cmd(1'b1, 4'd0, 5'd0, 5'd0, 5'd1, 4'd0, 1'b0, 32'hFFFF_FFCB);
        n_total++;
        if (ob_res !== 32'hFFFF_FFCB || ob_lat != 2)
            $display("FAIL li1_rsp: got res=%h lat=%0d expected res=ffffffcb lat=2", ob_res, ob_lat);
        else n_pass++;
        n_total++;
        if (ob_we_cnt != 1 || ob_mux !== 1'b0 || ob_wr !== 5'd1)
            $display("FAIL li1_we: got we_cnt=%0d mux=%b wr=%0d expected 1/0/1", ob_we_cnt, ob_mux, ob_wr);
        else n_pass++;
        send_cmd(1'b1, 4'd0, 5'd0, 5'd0, 5'd2, 4'd0, 1'b0, 32'd3);
        model_cmd(1'b1, 4'd0, 5'd0, 5'd0, 5'd2, 4'd0, 1'b0, 32'd3);
        n_total++;
        if (ob_res !== 32'd3 || ob_lat != 2 || ob_we_cnt != 1 || ob_wr !== 5'd2 || ob_after !== 1'b0)
            $display("FAIL li2: got res=%h lat=%0d we_cnt=%0d wr=%0d after=%b expected 3/2/1/2/0",
                     ob_res, ob_lat, ob_we_cnt, ob_wr, ob_after);
        else n_pass++;
    endtask

    task automatic test_alu_add();
        send_cmd(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 4'd0, 1'b0, 32'd0);
        model_cmd(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 4'd0, 1'b0, 32'd0);
        n_total++;
        if (ob_rr1 !== 5'd1 || ob_rr2 !== 5'd2)
            $display("FAIL add_rd_addr: got rr1=%0d rr2=%0d expected 1 2", ob_rr1, ob_rr2);
        else n_pass++;
        n_total++;
        if (ob_we_cnt != 1 || ob_mux !== 1'b1 || ob_wr !== 5'd3)
            $display("FAIL add_we: got we_cnt=%0d mux=%b wr=%0d expected 1/1/3", ob_we_cnt, ob_mux, ob_wr);
        else n_pass++;
        n_total++;
        if (ob_res !== 32'hFFFF_FFCE || ob_lat != 4 || ob_err !== 1'b0)
            $display("FAIL add_rsp: got res=%h lat=%0d err=%b expected ffffffce/4/0", ob_res, ob_lat, ob_err);
        else n_pass++;
        n_total++;
        if (rf[3] !== 32'hFFFF_FFCE) $display("FAIL add_rf3: got %h expected ffffffce", rf[3]);
        else n_pass++;
    endtask

    task automatic test_shift();
        send_cmd(1'b1, 4'd0, 5'd0, 5'd0, 5'd1, 4'd0, 1'b0, 32'hFFFF_FFFB);
        model_cmd(1'b1, 4'd0, 5'd0, 5'd0, 5'd1, 4'd0, 1'b0, 32'hFFFF_FFFB);
        send_cmd(1'b0, 4'd6, 5'd1, 5'd0, 5'd4, 4'd2, 1'b0, 32'd0);
        model_cmd(1'b0, 4'd6, 5'd1, 5'd0, 5'd4, 4'd2, 1'b0, 32'd0);
        n_total++;
        if (ob_res !== 32'hFFFF_FFFE || ob_lat != 4)
            $display("FAIL sra_rsp: got res=%h lat=%0d expected fffffffe/4", ob_res, ob_lat);
        else n_pass++;
    endtask

    task automatic test_illegal();
        send_cmd(1'b0, 4'd0, 5'd1, 5'd2, 5'd9, 4'd0, 1'b0, 32'd0);
        n_total++;
        if (ob_lat != 1 || ob_err !== 1'b1 || ob_res !== 32'd0 || ob_we_cnt != 0)
            $display("FAIL illegal_rd: got lat=%0d err=%b res=%h we_cnt=%0d expected 1/1/0/0",
                     ob_lat, ob_err, ob_res, ob_we_cnt);
        else n_pass++;
        send_cmd(1'b0, 4'd0, 5'd12, 5'd2, 5'd5, 4'd0, 1'b0, 32'd0);
        n_total++;
        if (ob_lat != 1 || ob_err !== 1'b1 || ob_we_cnt != 0)
            $display("FAIL illegal_rs1: got lat=%0d err=%b we_cnt=%0d expected 1/1/0", ob_lat, ob_err, ob_we_cnt);
        else n_pass++;
        // load-immediate ignores rs1/rs2
        send_cmd(1'b1, 4'd0, 5'd20, 5'd31, 5'd5, 4'd0, 1'b0, 32'h1234_5678);
        model_cmd(1'b1, 4'd0, 5'd20, 5'd31, 5'd5, 4'd0, 1'b0, 32'h1234_5678);
        n_total++;
        if (ob_lat != 2 || ob_err !== 1'b0 || ob_res !== 32'h1234_5678 || ob_we_cnt != 1)
            $display("FAIL li_ignores_rs: got lat=%0d err=%b res=%h we_cnt=%0d expected 2/0/12345678/1",
                     ob_lat, ob_err, ob_res, ob_we_cnt);
        else n_pass++;
    endtask

    task automatic test_r0();
        send_cmd(1'b1, 4'd0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 32'd7);
        model_cmd(1'b1, 4'd0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 32'd7);
`ifdef ALU_SEQ_R0_ZERO_EN
        n_total++;
        if (ob_we_cnt != 0 || ob_res !== 32'd0 || ob_err !== 1'b0 || ob_lat != 2)
            $display("FAIL r0_protect: got we_cnt=%0d res=%h err=%b lat=%0d expected 0/0/0/2",
                     ob_we_cnt, ob_res, ob_err, ob_lat);
        else n_pass++;
`else
        n_total++;
        if (ob_we_cnt != 1 || ob_res !== 32'd7 || ob_wr !== 5'd0)
            $display("FAIL r0_plain: got we_cnt=%0d res=%h wr=%0d expected 1/7/0", ob_we_cnt, ob_res, ob_wr);
        else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        int cyc, nacc, t0, t1, nrsp, low;
        bit rdy;
        logic [31:0] r0v, r1v, x0, x1;
        cyc = 0; nacc = 0; t0 = 0; t1 = 0; nrsp = 0; low = 0; r0v = '0; r1v = '0;
        model_cmd(1'b0, 4'd0, 5'd1, 5'd2, 5'd5, 4'd0, 1'b0, 32'd0); x0 = e_res;
        model_cmd(1'b0, 4'd1, 5'd5, 5'd3, 5'd6, 4'd0, 1'b0, 32'd0); x1 = e_res;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_li = 1'b0; bus.cmd_op = 4'd0; bus.cmd_rs1 = 5'd1;
        bus.cmd_rs2 = 5'd2; bus.cmd_rd = 5'd5; bus.cmd_shamt = 4'd0; bus.cmd_sign = 1'b0;
        while (cyc < 30) begin
            if (bus.rsp_valid) begin
                if (nrsp == 0) r0v = bus.rsp_result; else r1v = bus.rsp_result;
                nrsp++;
            end
            rdy = bus.cmd_ready;
            if (nacc == 1 && !rdy) low++;
            @(posedge clk);
            cyc++;
            if (rdy && bus.cmd_valid) begin
                nacc++;
                #1;
                if (nacc == 1) begin
                    t0 = cyc;
                    bus.cmd_op = 4'd1; bus.cmd_rs1 = 5'd5; bus.cmd_rs2 = 5'd3; bus.cmd_rd = 5'd6;
                end else begin
                    t1 = cyc;
                    bus.cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        n_total++;
        if (nacc != 2 || t1 - t0 != 5)
            $display("FAIL b2b_gap: got accepts=%0d gap=%0d expected 2/5", nacc, t1 - t0);
        else n_pass++;
        n_total++;
        if (low != 4) $display("FAIL b2b_ready_low: got %0d busy cycles expected 4", low);
        else n_pass++;
        n_total++;
        if (nrsp != 2 || r0v !== x0 || r1v !== x1)
            $display("FAIL b2b_rsp: got n=%0d r0=%h r1=%h expected 2/%h/%h", nrsp, r0v, r1v, x0, x1);
        else n_pass++;
    endtask

    task automatic test_reset_in_wb();
        int w;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_li = 1'b0; bus.cmd_op = 4'd0; bus.cmd_rs1 = 5'd3;
        bus.cmd_rs2 = 5'd3; bus.cmd_rd = 5'd7; bus.cmd_shamt = 4'd0; bus.cmd_sign = 1'b0;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        @(posedge clk); #1;           // RD
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;           // EX
        @(posedge clk); #1;           // WB
        n_total++;
        if (bus.we !== 1'b1) $display("FAIL rstwb_in_wb: got we=%b expected 1", bus.we);
        else n_pass++;
        rst_n = 1'b0;
        // the register file still takes the write at this edge (we was high)
        mreg[7] = mreg[3] + mreg[3];
        @(posedge clk); #1;
        n_total++;
        if (bus.we !== 1'b0 || bus.rsp_valid !== 1'b0)
            $display("FAIL rstwb_we_drop: got we=%b rsp=%b expected 0 0", bus.we, bus.rsp_valid);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
            $display("FAIL rstwb_release: got ready=%b rsp=%b expected 1 0", bus.cmd_ready, bus.rsp_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        bit li, sg;
        logic [3:0] o, sh;
        logic [4:0] rs1, rs2, rd;
        logic [31:0] imm;
        for (int i = 0; i < 40; i++) begin
            li  = ($urandom_range(0, 2) == 0);
            o   = 4'($urandom_range(0, 15));
            rs1 = 5'($urandom_range(0, 9));
            rs2 = 5'($urandom_range(0, 9));
            rd  = 5'($urandom_range(0, 9));
            sh  = 4'($urandom);
            sg  = 1'($urandom);
            imm = $urandom;
            send_cmd(li, o, rs1, rs2, rd, sh, sg, imm);
            model_cmd(li, o, rs1, rs2, rd, sh, sg, imm);
            n_total++;
            if (ob_acc_to || ob_lat != e_lat || ob_err !== e_err || ob_res !== e_res)
                $display("FAIL rnd%0d_rsp: got to=%b lat=%0d err=%b res=%h expected 0/%0d/%b/%h",
                         i, ob_acc_to, ob_lat, ob_err, ob_res, e_lat, e_err, e_res);
            else n_pass++;
            n_total++;
            if (ob_we_cnt != int'(e_we) || (e_we && (ob_wr !== rd || ob_mux !== !li)))
                $display("FAIL rnd%0d_we: got cnt=%0d wr=%0d mux=%b expected %0d/%0d/%b",
                         i, ob_we_cnt, ob_wr, ob_mux, e_we, rd, !li);
            else n_pass++;
            n_total++;
            if (ob_ready_busy != 0 || ob_after !== 1'b0)
                $display("FAIL rnd%0d_hs: got ready_busy=%0d rsp_after=%b expected 0 0", i, ob_ready_busy, ob_after);
            else n_pass++;
            if (!e_err) begin
                n_total++;
                if (rf[rd] !== mreg[rd[2:0]])
                    $display("FAIL rnd%0d_rf: got r%0d=%h expected %h", i, rd, rf[rd], mreg[rd[2:0]]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        for (int i = 0; i < 8; i++) mreg[i] = 32'd0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        scramble();
        test_reset();
        test_load_imm();
        test_alu_add();
        test_shift();
        test_illegal();
        test_r0();
        test_back_to_back();
        test_reset_in_wb();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
